// File: rtl/raymarch_pkg.sv
// ---------------------------------------------------------------------------
// raymarch_pkg
// Shared definitions for the pixel scheduler:
//   - scheduler state encoding (IDLE, RENDER, DRAIN, DONE)
//   - framebuffer pixel width PIX_W
//   - colour packing helper pack_rgb()
// Build option: define PIXEL_SCHED_RGB565_EN for RGB565 (PIX_W=16).
// Without it the framebuffer pixel is RGB444 (PIX_W=12).
// ---------------------------------------------------------------------------
package raymarch_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_RENDER = 2'd1;
   localparam state_t S_DRAIN  = 2'd2;
   localparam state_t S_DONE   = 2'd3;

`ifdef PIXEL_SCHED_RGB565_EN
   localparam int unsigned PIX_W = 16;
`else
   localparam int unsigned PIX_W = 12;
`endif

   // Reduce an 8/8/8 colour to the framebuffer format by keeping the MSBs.
   function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
`ifdef PIXEL_SCHED_RGB565_EN
      return {r[7:3], g[7:2], b[7:3]};
`else
      return {r[7:4], g[7:4], b[7:4]};
`endif
   endfunction

endpackage

// File: rtl/pixel_scheduler_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Raster-order x/y position counter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous return to (0,0)
//   advance     step one pixel; x wraps WIDTH-1 -> 0 with y+1,
//               and (WIDTH-1,HEIGHT-1) wraps to (0,0)
//   x, y        current position
//   at_last     high while the position is (WIDTH-1,HEIGHT-1)
// ---------------------------------------------------------------------------
module raster_counter #(
   parameter int unsigned WIDTH  = 1280,
   parameter int unsigned HEIGHT = 720
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        advance,
   output logic [$clog2(WIDTH)-1:0]    x,
   output logic [$clog2(HEIGHT)-1:0]   y,
   output logic                        at_last
);

   localparam int unsigned X_W = $clog2(WIDTH);
   localparam int unsigned Y_W = $clog2(HEIGHT);
   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   logic x_last;
   logic y_last;

   always_comb begin
      x_last  = (x == X_LAST);
      y_last  = (y == Y_LAST);
      at_last = x_last && y_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_scheduler.sv
// ---------------------------------------------------------------------------
// pixel_scheduler
// Issues pixel coordinates to the raymarcher in raster order, writes each
// completed pixel to the framebuffer BRAM port, and frames one full render
// with a start/done handshake.
// Ports:
//   clk_in, rst_n_in         clock, asynchronous active-low reset
//   frame_start              pulse: begin a frame (ignored while busy/done)
//   pixel_done               raymarcher result strobe (one cycle)
//   out_x, out_y             coordinates of the completed pixel
//   red_in/green_in/blue_in  completed pixel colour
//   curr_x, curr_y           next pixel offered to the raymarcher
//   fb_we, fb_addr, fb_data  framebuffer write port (addr = y*WIDTH+x)
//   busy                     high from accepted frame_start until frame_done
//   frame_done               pulse after the last framebuffer write
// Build option: PIXEL_SCHED_RGB565_EN selects RGB565 fb_data (else RGB444).
// ---------------------------------------------------------------------------
module pixel_scheduler
   import raymarch_pkg::*;
#(
   parameter int unsigned WIDTH  = 1280,
   parameter int unsigned HEIGHT = 720,
   parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        frame_start,
   input  logic                        pixel_done,
   input  logic [$clog2(WIDTH)-1:0]    out_x,
   input  logic [$clog2(HEIGHT)-1:0]   out_y,
   input  logic [7:0]                  red_in,
   input  logic [7:0]                  green_in,
   input  logic [7:0]                  blue_in,
   output logic [$clog2(WIDTH)-1:0]    curr_x,
   output logic [$clog2(HEIGHT)-1:0]   curr_y,
   output logic                        fb_we,
   output logic [ADDR_W-1:0]           fb_addr,
   output logic [PIX_W-1:0]            fb_data,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int unsigned N_PIX = WIDTH * HEIGHT;
   localparam int unsigned CNT_W = $clog2(N_PIX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);

   state_t             state;
   logic               pixel_done_d1;
   logic               pending;      // pixel in flight was issued in RENDER
   logic               last_issued;  // final pixel of the frame handed out
   logic [CNT_W-1:0]   result_cnt;
   logic               advance;
   logic               at_last;
   logic               raster_clear;
   logic               write_now;
   logic [ADDR_W-1:0]  pix_addr;

   // The raymarcher samples curr_x/curr_y on the edge where pixel_done_d1 is
   // high, so the raster steps on that same edge.
   always_comb begin
      advance      = (state == S_RENDER) && pixel_done_d1;
      raster_clear = (state == S_IDLE);
      write_now    = pixel_done && pending && (state != S_IDLE);
      pix_addr     = ADDR_W'(out_y) * ADDR_W'(WIDTH) + ADDR_W'(out_x);
   end

   raster_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_raster (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .clear   (raster_clear),
      .advance (advance),
      .x       (curr_x),
      .y       (curr_y),
      .at_last (at_last)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= S_IDLE;
         pixel_done_d1 <= 1'b0;
         pending       <= 1'b0;
         last_issued   <= 1'b0;
         result_cnt    <= '0;
         fb_we         <= 1'b0;
         fb_addr       <= '0;
         fb_data       <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         pixel_done_d1 <= pixel_done;
         fb_we         <= 1'b0;
         frame_done    <= 1'b0;

         // A pixel sampled outside RENDER (idle, drain) must never be
         // written, so the tag is taken from the state at the sample edge.
         if (pixel_done_d1) begin
            pending <= (state == S_RENDER);
         end else if (pixel_done) begin
            pending <= 1'b0;
         end

         if (write_now) begin
            fb_we   <= 1'b1;
            fb_addr <= pix_addr;
            fb_data <= pack_rgb(red_in, green_in, blue_in);
         end

         if (fb_we) begin
            result_cnt <= result_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state       <= S_RENDER;
                  busy        <= 1'b1;
                  result_cnt  <= '0;
                  last_issued <= 1'b0;
               end
            end
            S_RENDER: begin
               if (advance && at_last) begin
                  last_issued <= 1'b1;
                  state       <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Leave on the edge ending the final write so DONE lands in
               // the very next cycle.
               if (fb_we && last_issued && (result_cnt == CNT_LAST)) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // The raymarcher needs at least three cycles per pixel, so a new result
   // can never coincide with the sample cycle of the previous one.
   a_no_overlap: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                  !(pixel_done && pixel_done_d1));
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pixel_scheduler
// Bench for pixel_scheduler at WIDTH=4, HEIGHT=3 with a behavioural
// raymarcher (5 cycles per pixel). A frame-level model predicts every output
// each cycle; literal expectations pin addresses, colour packing and
// frame_done counts.
// ---------------------------------------------------------------------------
module tb_pixel_scheduler;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int PW = raymarch_pkg::PIX_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          frame_start = 1'b0;
   logic          pixel_done = 1'b0;
   logic [1:0]    out_x = '0;
   logic [1:0]    out_y = '0;
   logic [7:0]    red = '0;
   logic [7:0]    green = '0;
   logic [7:0]    blue = '0;
   logic [1:0]    curr_x;
   logic [1:0]    curr_y;
   logic          fb_we;
   logic [3:0]    fb_addr;
   logic [PW-1:0] fb_data;
   logic          busy;
   logic          frame_done;

   always #5 clk = ~clk;

   pixel_scheduler #(
      .WIDTH  (W),
      .HEIGHT (H)
   ) dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .frame_start (frame_start),
      .pixel_done  (pixel_done),
      .out_x       (out_x),
      .out_y       (out_y),
      .red_in      (red),
      .green_in    (green),
      .blue_in     (blue),
      .curr_x      (curr_x),
      .curr_y      (curr_y),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pack_model(input int r, input int g, input int b);
`ifdef PIXEL_SCHED_RGB565_EN
      return ((r / 8) << 11) | ((g / 4) << 5) | (b / 8);
`else
      return ((r / 16) << 8) | ((g / 16) << 4) | (b / 16);
`endif
   endfunction

   // ---------------- frame-level model ----------------
   bit m_render;         // frame still handing out pixels
   int m_issued;
   int m_written;
   int m_cx, m_cy;
   bit m_prev_pd;
   bit tags[$];          // per pixel in flight: issued inside a frame?
   bit e_we, e_busy, e_done;
   int e_addr, e_data;

   int wr_log[$];
   int data0 = -1;
   int done_count = 0;

   task automatic model_reset();
      m_render  = 0;
      m_issued  = 0;
      m_written = 0;
      m_cx      = 0;
      m_cy      = 0;
      m_prev_pd = 0;
      tags.delete();
      e_we   = 0;
      e_busy = 0;
      e_done = 0;
      e_addr = 0;
      e_data = 0;
   endtask

   task automatic model_step();
      bit n_we, n_busy, n_done, tag;
      int n_addr, n_data;
      n_we   = 0;
      n_addr = e_addr;
      n_data = e_data;
      if (pixel_done) begin
         tag = (tags.size() > 0) ? tags.pop_front() : 1'b0;
         if (tag) begin
            n_we   = 1;
            n_addr = int'(out_y) * W + int'(out_x);
            n_data = pack_model(int'(red), int'(green), int'(blue));
         end
      end
      if (m_prev_pd) begin
         tags.push_back(m_render);
         if (m_render) begin
            m_issued++;
            m_cx++;
            if (m_cx == W) begin
               m_cx = 0;
               m_cy++;
            end
            if (m_issued == N) begin
               m_render = 0;
               m_cx = 0;
               m_cy = 0;
            end
         end
      end
      m_prev_pd = pixel_done;
      n_done = 0;
      n_busy = e_busy;
      if (e_we) begin
         m_written++;
         if (m_written == N) begin
            n_done = 1;
            n_busy = 0;
         end
      end
      if (frame_start && !e_busy && !e_done) begin
         n_busy    = 1;
         m_render  = 1;
         m_issued  = 0;
         m_written = 0;
      end
      e_we   = n_we;
      e_busy = n_busy;
      e_done = n_done;
      e_addr = n_addr;
      e_data = n_data;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("fb_we", int'(fb_we), int'(e_we));
      chk("busy", int'(busy), int'(e_busy));
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("curr_x", int'(curr_x), m_cx);
      chk("curr_y", int'(curr_y), m_cy);
      if (e_we) begin
         chk("fb_addr", int'(fb_addr), e_addr);
         chk("fb_data", int'(fb_data), e_data);
      end
      if (fb_we) begin
         wr_log.push_back(int'(fb_addr));
         if (fb_addr == 4'd0) data0 = int'(fb_data);
      end
      if (frame_done) done_count++;
      if (rst_n) model_step();
   end

   // ---------------- behavioural raymarcher ----------------
   task automatic raymarcher();
      int sx = 0;
      int sy = 0;
      forever begin
         repeat (4) @(posedge clk);
         #1;
         pixel_done = 1'b1;
         out_x = 2'(sx);
         out_y = 2'(sy);
         red   = 8'hAB + 8'(sx * 16);
         green = 8'hCD + 8'(sy * 16);
         blue  = 8'hEF ^ 8'(sx * sy * 16);
         @(posedge clk);
         #1 pixel_done = 1'b0;
         @(negedge clk);
         sx = int'(curr_x);
         sy = int'(curr_y);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_fb_we"}, int'(fb_we), 0);
      chk({tag, "_fb_addr"}, int'(fb_addr), 0);
      chk({tag, "_fb_data"}, int'(fb_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_curr_x"}, int'(curr_x), 0);
      chk({tag, "_curr_y"}, int'(curr_y), 0);
   endtask

   task automatic chk_frame_log(input string tag);
      chk({tag, "_write_count"}, wr_log.size(), N);
      for (int i = 0; i < wr_log.size() && i < N; i++)
         chk($sformatf("%s_addr%0d", tag, i), wr_log[i], i);
   endtask

   initial begin
      bit seen;
      #1 rst_n = 1'b0;
      #3 chk_outputs_zero("reset_init");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      fork
         raymarcher();
      join_none

      // Spurious post-reset result must not be written.
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = pixel_done;
      end
      chk("spurious_pd_seen", int'(seen), 1);
      // Frame start while the IDLE-issued (0,0) is mid-flight.
      repeat (3) @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      chk("spurious_discarded", wr_log.size(), 0);

      // Try to restart the frame while draining.
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = (m_issued == N) && !m_render && (done_count == 0);
      end
      chk("reached_drain", int'(seen), 1);
      pulse_start();

      for (int i = 0; i < 100 && done_count == 0; i++) @(negedge clk);
      chk("frame1_done", done_count, 1);
      chk_frame_log("frame1");
      chk("frame1_colour_addr0",
          data0, (PW == 16) ? 32'hAE7D : 32'hACE);
      repeat (20) @(negedge clk);
      chk("drain_start_ignored_done", done_count, 1);
      chk("drain_start_ignored_busy", int'(busy), 0);
      chk("drain_start_ignored_writes", wr_log.size(), N);

      // Abort a frame with reset after six writes.
      wr_log.delete();
      pulse_start();
      for (int i = 0; i < 200 && wr_log.size() < 6; i++) @(negedge clk);
      chk("abort_six_writes", wr_log.size(), 6);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("reset_mid");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wr_log.delete();
      repeat (40) @(negedge clk);
      chk("abort_no_done", done_count, 1);
      chk("abort_no_writes", wr_log.size(), 0);

      // Fresh frame after the abort restarts at address 0.
      data0 = -1;
      pulse_start();
      for (int i = 0; i < 200 && done_count < 2; i++) @(negedge clk);
      chk("frame3_done", done_count, 2);
      chk_frame_log("frame3");
      chk("frame3_colour_addr0",
          data0, (PW == 16) ? 32'hAE7D : 32'hACE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
